// File: rtl/oam_dma_ctrl.sv
// -----------------------------------------------------------------------------
// oam_dma_ctrl
//   Sprite (OAM) DMA controller and memory-bus arbiter between the 6502 CPU
//   core and system memory. When the CPU writes a page number P to
//   DMA_REG_ADDR, the CPU is halted and XFER_LEN bytes are copied from
//   {P,8'h00} upward to OAM_DATA_ADDR. The copy is done as read/write pairs
//   whose read always lands on an even cycle. When no transfer is running the
//   block is a transparent pass-through between the CPU and memory ports.
//
// Parameters
//   DMA_REG_ADDR   CPU write address that triggers a transfer
//   OAM_DATA_ADDR  destination address of every DMA write
//   XFER_LEN       bytes per transfer, legal range 1..256
//
// Ports
//   clk        in   system clock, all state changes on the rising edge
//   rst        in   asynchronous active-low reset (0 = reset)
//   cpu_addr   in   CPU address
//   cpu_d_out  in   CPU write data
//   cpu_we     in   CPU write strobe
//   cpu_d_in   out  read data to CPU (always the memory read data)
//   cpu_halt   out  1 = CPU must hold its state this cycle
//   mem_addr   out  memory address
//   mem_d_out  out  memory write data
//   mem_we     out  memory write strobe
//   mem_d_in   in   memory read data, valid by the end of its address cycle
//   dma_busy   out  1 while a transfer is in progress
//   dma_done   out  one-cycle pulse in the cycle after the final DMA write
// -----------------------------------------------------------------------------
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_we,
  output logic [7:0]  cpu_d_in,
  output logic        cpu_halt,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_d_out,
  output logic        mem_we,
  input  logic [7:0]  mem_d_in,
  output logic        dma_busy,
  output logic        dma_done
);

  // Index of the final byte; idx is 8 bits so XFER_LEN=256 ends at 255.
  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  state_t      r_state;
  logic [7:0]  r_page;
  logic [7:0]  r_idx;
  logic [7:0]  r_buf;
  logic        r_odd;
  logic        r_done;

  state_t      w_state_nxt;
  logic [7:0]  w_page_nxt;
  logic [7:0]  w_idx_nxt;
  logic [7:0]  w_buf_nxt;
  logic        w_done_nxt;
  logic [15:0] w_mem_addr;
  logic [7:0]  w_mem_d_out;
  logic        w_mem_we;
  logic        w_halt;

  // State and datapath registers; r_odd is the free-running cycle parity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_page  <= 8'h00;
      r_idx   <= 8'h00;
      r_buf   <= 8'h00;
      r_odd   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_page  <= w_page_nxt;
      r_idx   <= w_idx_nxt;
      r_buf   <= w_buf_nxt;
      r_odd   <= ~r_odd;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic and the memory-bus mux driven from the current state.
  always_comb begin
    w_state_nxt = r_state;
    w_page_nxt  = r_page;
    w_idx_nxt   = r_idx;
    w_buf_nxt   = r_buf;
    w_done_nxt  = 1'b0;
    w_mem_addr  = cpu_addr;
    w_mem_d_out = cpu_d_out;
    w_mem_we    = 1'b0;
    w_halt      = 1'b1;

    case (r_state)
      ST_IDLE: begin
        // Pass-through; the trigger write itself still reaches memory.
        w_halt   = 1'b0;
        w_mem_we = cpu_we;
        if (cpu_we && (cpu_addr == DMA_REG_ADDR)) begin
          w_page_nxt  = cpu_d_out;
          w_idx_nxt   = 8'h00;
          w_state_nxt = ST_HALT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_HALT: begin
        // An odd HALT cycle means the next cycle is even, so READ can start.
        if (r_odd) begin
          w_state_nxt = ST_READ;
        end else begin
          w_state_nxt = ST_ALIGN;
        end
      end

      ST_ALIGN: begin
        w_state_nxt = ST_READ;
      end

      ST_READ: begin
        w_mem_addr  = {r_page, r_idx};
        w_buf_nxt   = mem_d_in;
        w_state_nxt = ST_WRITE;
      end

      ST_WRITE: begin
        w_mem_addr  = OAM_DATA_ADDR;
        w_mem_d_out = r_buf;
        w_mem_we    = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_idx_nxt   = r_idx + 8'd1;
          w_state_nxt = ST_READ;
        end
      end

      default: begin
        // Unreachable encoding: release the CPU and fall back to IDLE.
        w_halt      = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign cpu_d_in  = mem_d_in;
  assign cpu_halt  = w_halt;
  assign dma_busy  = w_halt;
  assign dma_done  = r_done;
  assign mem_addr  = w_mem_addr;
  assign mem_d_out = w_mem_d_out;
  assign mem_we    = w_mem_we;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
module tb_oam_dma_ctrl;

  logic        clk;
  logic        rst;

  logic [15:0] a_cpu_addr, a_mem_addr;
  logic [7:0]  a_cpu_d_out, a_cpu_d_in, a_mem_d_out, a_mem_d_in;
  logic        a_cpu_we, a_cpu_halt, a_mem_we, a_dma_busy, a_dma_done;

  logic [15:0] b_cpu_addr, b_mem_addr;
  logic [7:0]  b_cpu_d_out, b_cpu_d_in, b_mem_d_out, b_mem_d_in;
  logic        b_cpu_we, b_cpu_halt, b_mem_we, b_dma_busy, b_dma_done;

  logic [7:0]  mem_a [0:65535];
  logic [7:0]  mem_b [0:65535];

  logic [7:0]  q_exp [$];

  int n_vec;
  int n_err;
  int tb_cyc;
  logic tb_odd;

  oam_dma_ctrl u_dut_a (
    .clk(clk), .rst(rst),
    .cpu_addr(a_cpu_addr), .cpu_d_out(a_cpu_d_out), .cpu_we(a_cpu_we),
    .cpu_d_in(a_cpu_d_in), .cpu_halt(a_cpu_halt),
    .mem_addr(a_mem_addr), .mem_d_out(a_mem_d_out), .mem_we(a_mem_we),
    .mem_d_in(a_mem_d_in), .dma_busy(a_dma_busy), .dma_done(a_dma_done)
  );

  oam_dma_ctrl #(.XFER_LEN(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .cpu_addr(b_cpu_addr), .cpu_d_out(b_cpu_d_out), .cpu_we(b_cpu_we),
    .cpu_d_in(b_cpu_d_in), .cpu_halt(b_cpu_halt),
    .mem_addr(b_mem_addr), .mem_d_out(b_mem_d_out), .mem_we(b_mem_we),
    .mem_d_in(b_mem_d_in), .dma_busy(b_dma_busy), .dma_done(b_dma_done)
  );

  assign a_mem_d_in = mem_a[a_mem_addr];
  assign b_mem_d_in = mem_b[b_mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle counter / parity: cycle k after reset release has odd = k%2.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      tb_cyc <= 0;
      tb_odd <= 1'b0;
    end else begin
      tb_cyc <= tb_cyc + 1;
      tb_odd <= ~tb_odd;
    end
  end

  task automatic test_reset();
    a_cpu_addr = 16'h1234; a_cpu_d_out = 8'h77; a_cpu_we = 1'b1;
    #1;
    n_vec++; if (a_mem_addr !== 16'h1234) begin n_err++; $display("FAIL rst_addr: got %h expected %h", a_mem_addr, 16'h1234); end
    n_vec++; if (a_mem_d_out !== 8'h77) begin n_err++; $display("FAIL rst_dout: got %h expected %h", a_mem_d_out, 8'h77); end
    n_vec++; if (a_mem_we !== 1'b1) begin n_err++; $display("FAIL rst_we: got %b expected 1", a_mem_we); end
    n_vec++; if ({a_cpu_halt, a_dma_busy, a_dma_done} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b expected 000", {a_cpu_halt, a_dma_busy, a_dma_done}); end
    n_vec++; if ({b_cpu_halt, b_dma_busy, b_dma_done} !== 3'b000) begin n_err++; $display("FAIL rst_flags_b: got %b expected 000", {b_cpu_halt, b_dma_busy, b_dma_done}); end
    a_cpu_we = 1'b0;
  endtask

  // Full 256-byte transfer of page 02 triggered during cycle trig_cyc.
  task automatic test_transfer(input int trig_cyc);
    int exp_halt, halts, nwr, rd_i, first_rd;
    bit done_seen;
    logic [7:0] exp_d;
    while (tb_cyc < trig_cyc) @(negedge clk);
    exp_halt = 513 + (trig_cyc % 2);
    a_cpu_addr = 16'h4014; a_cpu_d_out = 8'h02; a_cpu_we = 1'b1;
    #1;
    n_vec++; if ({a_mem_we, a_mem_addr, a_mem_d_out} !== {1'b1, 16'h4014, 8'h02}) begin n_err++; $display("FAIL trig_passthru: got %b/%h/%h expected 1/4014/02", a_mem_we, a_mem_addr, a_mem_d_out); end
    for (int i = 0; i < 256; i++) q_exp.push_back(8'(i) ^ 8'hA5);
    halts = 0; nwr = 0; rd_i = 0; first_rd = -1; done_seen = 1'b0;
    for (int c = 0; c < 600 && !done_seen; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_vec++; if (a_cpu_halt !== 1'b1) begin n_err++; $display("FAIL halt_start: got %b expected 1 at cycle %0d", a_cpu_halt, tb_cyc); end
      end
      if (a_dma_busy !== a_cpu_halt) begin n_err++; $display("FAIL busy_eq_halt: got %b expected %b", a_dma_busy, a_cpu_halt); end
      n_vec++;
      if (a_cpu_halt === 1'b1) halts++;
      if (a_cpu_halt && a_mem_we) begin
        n_vec++; if (a_mem_addr !== 16'h2004 || tb_odd !== 1'b1) begin n_err++; $display("FAIL wr_addr: got %h odd %b expected 2004 odd 1", a_mem_addr, tb_odd); end
        if (q_exp.size() == 0) begin
          n_vec++; n_err++; $display("FAIL extra_write: got data %h expected no write", a_mem_d_out);
        end else begin
          exp_d = q_exp.pop_front();
          n_vec++; if (a_mem_d_out !== exp_d) begin n_err++; $display("FAIL wr_data: got %h expected %h (write %0d)", a_mem_d_out, exp_d, nwr); end
        end
        nwr++;
      end else if (a_cpu_halt && a_mem_addr !== a_cpu_addr) begin
        if (first_rd < 0) first_rd = tb_cyc;
        n_vec++; if (a_mem_addr !== {8'h02, 8'(rd_i)} || tb_odd !== 1'b0) begin n_err++; $display("FAIL rd_addr: got %h odd %b expected %h odd 0", a_mem_addr, tb_odd, {8'h02, 8'(rd_i)}); end
        rd_i++;
      end
      if (a_dma_done === 1'b1) begin
        done_seen = 1'b1;
        n_vec++; if (tb_cyc !== trig_cyc + 1 + exp_halt) begin n_err++; $display("FAIL done_cycle: got %0d expected %0d", tb_cyc, trig_cyc + 1 + exp_halt); end
        n_vec++; if (a_cpu_halt !== 1'b0) begin n_err++; $display("FAIL done_halt: got %b expected 0", a_cpu_halt); end
      end
      a_cpu_we = 1'b0;
    end
    n_vec++; if (!done_seen) begin n_err++; $display("FAIL done_timeout: got no dma_done expected pulse"); end
    n_vec++; if (halts !== exp_halt) begin n_err++; $display("FAIL halt_len: got %0d expected %0d", halts, exp_halt); end
    n_vec++; if (first_rd !== trig_cyc + 2 + (trig_cyc % 2)) begin n_err++; $display("FAIL first_read: got %0d expected %0d", first_rd, trig_cyc + 2 + (trig_cyc % 2)); end
    n_vec++; if (nwr !== 256 || rd_i !== 256 || q_exp.size() !== 0) begin n_err++; $display("FAIL xfer_count: got %0d writes %0d reads expected 256/256", nwr, rd_i); end
    @(negedge clk);
    n_vec++; if ({a_dma_done, a_cpu_halt} !== 2'b00) begin n_err++; $display("FAIL done_pulse: got %b expected 00", {a_dma_done, a_cpu_halt}); end
    q_exp.delete();
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    a_cpu_addr = 16'h4015; a_cpu_d_out = 8'h5A; a_cpu_we = 1'b1;
    #1;
    n_vec++; if ({a_mem_we, a_mem_addr, a_mem_d_out} !== {1'b1, 16'h4015, 8'h5A}) begin n_err++; $display("FAIL pt_write: got %b/%h/%h expected 1/4015/5a", a_mem_we, a_mem_addr, a_mem_d_out); end
    @(negedge clk);
    n_vec++; if (a_dma_busy !== 1'b0) begin n_err++; $display("FAIL pt_no_dma_4015: got %b expected 0", a_dma_busy); end
    a_cpu_addr = 16'h4014; a_cpu_we = 1'b0;
    #1;
    n_vec++; if ({a_mem_we, a_mem_addr} !== {1'b0, 16'h4014}) begin n_err++; $display("FAIL pt_read: got %b/%h expected 0/4014", a_mem_we, a_mem_addr); end
    n_vec++; if (a_cpu_d_in !== 8'h3C) begin n_err++; $display("FAIL pt_rdata: got %h expected 3c", a_cpu_d_in); end
    @(negedge clk);
    n_vec++; if (a_dma_busy !== 1'b0 || a_cpu_halt !== 1'b0) begin n_err++; $display("FAIL pt_no_dma_read: got %b%b expected 00", a_dma_busy, a_cpu_halt); end
    a_cpu_addr = 16'h0000;
  endtask

  // XFER_LEN=4 instance with the CPU hammering the trigger register throughout.
  task automatic test_short_xfer();
    int exp_halt, halts, nwr, rd_i;
    bit done_seen;
    logic [7:0] exp_d;
    @(negedge clk);
    exp_halt = 9 + (tb_cyc % 2);
    b_cpu_addr = 16'h4014; b_cpu_d_out = 8'h07; b_cpu_we = 1'b1;
    for (int i = 0; i < 4; i++) q_exp.push_back(8'hC0 + 8'(i));
    halts = 0; nwr = 0; rd_i = 0; done_seen = 1'b0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      @(negedge clk);
      b_cpu_d_out = 8'h55;
      if (b_cpu_halt === 1'b1) halts++;
      if (b_cpu_halt && b_mem_we) begin
        n_vec++; if (b_mem_addr !== 16'h2004) begin n_err++; $display("FAIL b_wr_addr: got %h expected 2004", b_mem_addr); end
        exp_d = (q_exp.size() != 0) ? q_exp.pop_front() : 8'hXX;
        n_vec++; if (b_mem_d_out !== exp_d) begin n_err++; $display("FAIL b_wr_data: got %h expected %h", b_mem_d_out, exp_d); end
        nwr++;
      end else if (b_cpu_halt && b_mem_addr !== b_cpu_addr) begin
        n_vec++; if (b_mem_addr !== 16'h0700 + 16'(rd_i) || b_cpu_d_in !== 8'hC0 + 8'(rd_i)) begin n_err++; $display("FAIL b_rd: got %h/%h expected %h/%h", b_mem_addr, b_cpu_d_in, 16'h0700 + 16'(rd_i), 8'hC0 + 8'(rd_i)); end
        rd_i++;
      end
      if (b_dma_done === 1'b1) begin
        done_seen = 1'b1;
        b_cpu_we = 1'b0;
      end
    end
    n_vec++; if (!done_seen) begin n_err++; $display("FAIL b_done_timeout: got no dma_done expected pulse"); end
    n_vec++; if (halts !== exp_halt) begin n_err++; $display("FAIL b_halt_len: got %0d expected %0d", halts, exp_halt); end
    n_vec++; if (nwr !== 4 || rd_i !== 4 || q_exp.size() !== 0) begin n_err++; $display("FAIL b_count: got %0d writes %0d reads expected 4/4", nwr, rd_i); end
    @(negedge clk);
    n_vec++; if ({b_dma_busy, b_dma_done} !== 2'b00) begin n_err++; $display("FAIL b_no_restart: got %b expected 00", {b_dma_busy, b_dma_done}); end
    q_exp.delete();
  endtask

  task automatic test_reset_mid();
    int nwr;
    @(negedge clk);
    a_cpu_addr = 16'h4014; a_cpu_d_out = 8'h02; a_cpu_we = 1'b1;
    for (int i = 0; i < 256; i++) q_exp.push_back(8'(i) ^ 8'hA5);
    nwr = 0;
    for (int c = 0; c < 400 && nwr < 100; c++) begin
      @(negedge clk);
      a_cpu_we = 1'b0;
      if (a_cpu_halt && a_mem_we) begin
        nwr++;
        void'(q_exp.pop_front());
      end
    end
    n_vec++; if (nwr !== 100) begin n_err++; $display("FAIL mid_writes: got %0d expected 100", nwr); end
    rst = 1'b0;
    #1;
    n_vec++; if ({a_mem_we, a_cpu_halt, a_dma_busy, a_dma_done} !== 4'b0000) begin n_err++; $display("FAIL mid_rst_flags: got %b expected 0000", {a_mem_we, a_cpu_halt, a_dma_busy, a_dma_done}); end
    n_vec++; if (a_mem_addr !== a_cpu_addr) begin n_err++; $display("FAIL mid_rst_addr: got %h expected %h", a_mem_addr, a_cpu_addr); end
    q_exp.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_vec++; if ({a_mem_we, a_cpu_halt, a_dma_done} !== 3'b000) begin n_err++; $display("FAIL mid_after: got %b expected 000 at cycle %0d", {a_mem_we, a_cpu_halt, a_dma_done}, c); end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b0;
    a_cpu_addr = 16'h0000; a_cpu_d_out = 8'h00; a_cpu_we = 1'b0;
    b_cpu_addr = 16'h0000; b_cpu_d_out = 8'h00; b_cpu_we = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'hEE;
    end
    for (int i = 0; i < 256; i++) mem_a[16'h0200 + i] = 8'(i) ^ 8'hA5;
    mem_a[16'h4014] = 8'h3C;
    for (int i = 0; i < 4; i++) mem_b[16'h0700 + i] = 8'hC0 + 8'(i);
    repeat (3) @(posedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    test_transfer(4);
    begin
      int t;
      t = tb_cyc + 2;
      if (t % 2 == 0) t = t + 1;
      test_transfer(t);
    end
    test_passthrough();
    test_short_xfer();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
